// File: rtl/rmi_tx_packetizer.sv
// Transmit-side adapter: takes one RMI message from the node's output channel,
// splits it into RTSNoC flits stamped with fixed source/destination
// coordinates, and writes them to the router local port under wait_i
// backpressure.
module rmi_tx_packetizer #(
  parameter int unsigned       SIZE_X       = 1,
  parameter int unsigned       SIZE_Y       = 1,
  parameter int unsigned       SIZE_DATA    = 56,
  parameter int unsigned       RMI_MSG_SIZE = 80,
  parameter logic [SIZE_X-1:0] X            = 1'b1,
  parameter logic [SIZE_Y-1:0] Y            = 1'b1,
  parameter logic [2:0]        LOCAL_ADDR   = 3'b101,
  parameter logic [SIZE_X-1:0] DST_X        = 1'b0,
  parameter logic [SIZE_Y-1:0] DST_Y        = 1'b0,
  parameter logic [2:0]        DST_LOCAL    = 3'b000,
  localparam int unsigned      BUS_SIZE     = SIZE_DATA + 2 * SIZE_X + 2 * SIZE_Y + 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RMI_MSG_SIZE-1:0] tx_ch_z_i,
  input  logic                    tx_ch_lz_i,
  output logic                    tx_ch_vz_o,
  output logic [BUS_SIZE-1:0]     din_o,
  output logic                    wr_o,
  input  logic                    wait_i,
  output logic                    busy_o,
  output logic [15:0]             msg_cnt_o
);

  localparam int unsigned N_FLITS = (RMI_MSG_SIZE + SIZE_DATA - 1) / SIZE_DATA;
  localparam int unsigned CNT_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
  localparam int unsigned PAD_W   = N_FLITS * SIZE_DATA;
  localparam int unsigned HDR_W   = BUS_SIZE - SIZE_DATA;

  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(N_FLITS - 1);
  localparam logic [HDR_W-1:0] HEADER    = {DST_X, DST_Y, DST_LOCAL, X, Y, LOCAL_ADDR};

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic [RMI_MSG_SIZE-1:0] msg_q, msg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUS_SIZE-1:0]     din_q, din_d;
  logic                    wr_q, wr_d;
  logic                    vz_q, vz_d;
  logic [15:0]             msg_cnt_q, msg_cnt_d;

  logic msg_accept;
  logic flit_accept;
  logic last_flit;

  // Header plus payload slice idx; bits past the message end come out as zero.
  function automatic logic [BUS_SIZE-1:0] make_flit(input logic [RMI_MSG_SIZE-1:0] msg,
                                                    input int unsigned             idx);
    logic [PAD_W-1:0] padded;
    padded = PAD_W'(msg);
    return {HEADER, SIZE_DATA'(padded >> (idx * SIZE_DATA))};
  endfunction

  // vz_q gates lz so the node cannot slip a message in during the reset-exit cycle.
  assign msg_accept  = (state_q == StIdle) && vz_q && tx_ch_lz_i;
  assign flit_accept = (state_q == StSend) && wr_q && !wait_i;
  assign last_flit   = (cnt_q == LAST_FLIT);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (msg_accept) state_d = StSend;
      StSend:  if (flit_accept && last_flit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    msg_d     = msg_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    msg_cnt_d = msg_cnt_q;
    vz_d      = (state_d == StIdle);
    wr_d      = (state_d == StSend);
    if (msg_accept) begin
      msg_d = tx_ch_z_i;
      cnt_d = '0;
      din_d = make_flit(tx_ch_z_i, 0);
    end else if (flit_accept) begin
      if (last_flit) begin
        msg_cnt_d = msg_cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        din_d = make_flit(msg_q, 32'(cnt_q) + 32'd1);
      end
    end
  end

  // Datapath and output registers; reset drops any partial packet
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      msg_q     <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
      vz_q      <= 1'b0;
      msg_cnt_q <= '0;
    end else begin
      msg_q     <= msg_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      wr_q      <= wr_d;
      vz_q      <= vz_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  assign tx_ch_vz_o = vz_q;
  assign din_o      = din_q;
  assign wr_o       = wr_q;
  assign busy_o     = (state_q == StSend);
  assign msg_cnt_o  = msg_cnt_q;

endmodule
